board_turn_ctrl: RTL and testbench
==================================

Name: board_turn_ctrl

Overview:
- Owns both 2-player battleship boards: per-cell 3-bit state storage, ship placement, turn-based shot arbitration, hit/miss resolution and game-over detection.
- Feeds the VGA renderer's per-cell state lookup. The 3-bit cell code it returns goes straight into the colour mux for RGB.
- Sits between the player input front-ends (switch/button decoders) and the display path.

Parameters:
- ROWS, 5, board rows (1..8)
- COLS, 5, board columns (1..8)
- MAX_SHIPS, 5, maximum ship cells per board (1..ROWS*COLS)
- RW, 3, row index width (≥ clog2(ROWS))
- CW, 3, column index width (≥ clog2(COLS))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- place_valid  in  1  placement request, one cycle
- place_board  in  1  board receiving the ship cell
- place_row  in  RW  placement row
- place_col  in  CW  placement column
- place_err  out  1  placement rejected, one-cycle pulse
- start  in  1  end setup and begin play
- shot_req  in  2  bit p = player p requests a shot
- shot_row0, shot_col0  in  RW, CW  player 0 target
- shot_row1, shot_col1  in  RW, CW  player 1 target
- shot_ack  out  2  one-hot, one-cycle: shot of player p resolved
- shot_hit  out  1  valid with shot_ack; 1 = ship hit
- shot_rep  out  1  valid with shot_ack; 1 = rejected (repeat or out of range)
- pix_valid  in  1  renderer lookup valid
- pix_board  in  1  board to read
- pix_row, pix_col  in  RW, CW  cell to read
- cell_state  out  3  registered cell code for the renderer
- phase  out  2  00 SETUP, 01 WAIT_SHOT, 10 RESOLVE, 11 DONE
- turn  out  1  player allowed to fire
- game_over  out  1  level, high in DONE
- winner  out  1  valid when game_over

Behaviour:
- Cell codes: 000 none, 001 water, 010 water hit, 011 ship, 100 ship hit.
- Reset (rst=0 at a clk edge): all cells 001, ship counters 0, phase SETUP, turn 0. Outputs on reset: cell_state 000, all pulses 0, game_over 0, winner 0.
- SETUP:
  - place_valid with cell 001 and ships[place_board] < MAX_SHIPS → cell becomes 011 and ships incremented, effective next cycle.
  - Otherwise (cell already 011, counter full, or coordinates out of range) → place_err pulses next cycle and nothing changes.
  - start is accepted only when both ship counters are ≥1 → WAIT_SHOT. Otherwise start is ignored.
  - shot_req is ignored in SETUP.
- WAIT_SHOT:
  - Only shot_req[turn] is considered; the other bit is ignored and never acked.
  - On shot_req[turn]=1, the coordinates for player turn are latched, target board = ~turn, and the FSM goes to RESOLVE.
- RESOLVE (exactly one cycle): shot_ack[turn] pulses with shot_hit/shot_rep on the next edge. Resolution latency: request edge → ack 2 cycles.
  - Cell 001 → 010, hit=0, rep=0, turn toggles, → WAIT_SHOT.
  - Cell 011 → 100, hit=1, rep=0, ships[~turn] decrements. If the counter reaches 0 → DONE with winner=turn and turn unchanged. Otherwise turn toggles → WAIT_SHOT.
  - Cell 010 or 100, or out of range → no write, hit=0, rep=1, turn unchanged (the same player retries), → WAIT_SHOT.
- DONE: all requests are ignored and the board is frozen; exit only by reset.
- A requester holding shot_req high after ack fires again from the next WAIT_SHOT. Front-ends must edge-detect.
- Renderer read port:
  - cell_state is registered, 1-cycle latency, and independent of phase.
  - pix_valid=0 or out of range → 000.
  - Simultaneous write and read of the same cell returns the old value.
- Simultaneous place_valid and start in SETUP: the placement is applied and the start check uses the pre-placement counters.
- Reset mid-RESOLVE: no ack is issued and all state returns to reset values.

Test Plan:
- Reset, then read board0 (0,0) with pix_valid=1 → cell_state 001 one cycle later. pix_valid=0 → 000. pix_row=5 → 000.
- Place board1 (2,3) twice → first gives cell 011 and no err; second gives place_err pulse. Place 6 cells with MAX_SHIPS=5 → 6th gives err. start with board0 empty → phase stays 00.
- Each board gets 1 ship. start, then P0 shoots board1 empty cell (0,0) → ack=01, hit=0, rep=0, cell 010, turn=1. shot_req=01 while turn=1 → no ack.
- P1 repeats a water-hit cell → ack=10, rep=1, turn stays 1, no cell change. P1 shoots (7,7) → rep=1.
- P0 hits board1's only ship at (2,3) → ack=01, hit=1, cell 100, phase 11, game_over=1, winner=0. Further requests → no ack.
- Assert rst=0 during RESOLVE → no ack, all cells 001, phase 00, turn 0. Reset deasserted with rst=0 sampled only at clk edges (synchronous).

Source files
------------

// File: rtl/board_turn_ctrl.sv
// Two-board battleship controller: ship placement, turn arbitration, shot resolution, game over.
// Shot ack 2 cycles after the request edge; renderer read port has 1-cycle registered latency.
module board_turn_ctrl #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int MAX_SHIPS = 5,
  parameter int RW        = 3,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          place_valid,
  input  logic          place_board,
  input  logic [RW-1:0] place_row,
  input  logic [CW-1:0] place_col,
  output logic          place_err,
  input  logic          start,
  input  logic [1:0]    shot_req,
  input  logic [RW-1:0] shot_row0,
  input  logic [CW-1:0] shot_col0,
  input  logic [RW-1:0] shot_row1,
  input  logic [CW-1:0] shot_col1,
  output logic [1:0]    shot_ack,
  output logic          shot_hit,
  output logic          shot_rep,
  input  logic          pix_valid,
  input  logic          pix_board,
  input  logic [RW-1:0] pix_row,
  input  logic [CW-1:0] pix_col,
  output logic [2:0]    cell_state,
  output logic [1:0]    phase,
  output logic          turn,
  output logic          game_over,
  output logic          winner
);

  localparam int NC = ROWS * COLS;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam int SW = $clog2(MAX_SHIPS + 1);

  localparam logic [2:0] C_NONE      = 3'b000;
  localparam logic [2:0] C_WATER     = 3'b001;
  localparam logic [2:0] C_WATER_HIT = 3'b010;
  localparam logic [2:0] C_SHIP      = 3'b011;
  localparam logic [2:0] C_SHIP_HIT  = 3'b100;

  typedef enum logic [1:0] {
    SETUP     = 2'b00,
    WAIT_SHOT = 2'b01,
    RESOLVE   = 2'b10,
    DONE      = 2'b11
  } phase_t;

  function automatic logic in_range(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) < ROWS) && (int'(c) < COLS);
  endfunction

  // Out-of-range coordinates map to cell 0 so array reads stay in bounds; callers gate on in_range.
  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
    int tmp;
    tmp = in_range(r, c) ? (int'(r) * COLS + int'(c)) : 0;
    return IW'(tmp);
  endfunction

  logic [2:0]    cell_q [2][NC];
  logic [SW-1:0] ships_q [2];
  logic [SW-1:0] ships_d [2];

  phase_t        phase_q, phase_d;
  logic          turn_q, turn_d;
  logic          winner_q, winner_d;
  logic [RW-1:0] srow_q, srow_d;
  logic [CW-1:0] scol_q, scol_d;
  logic          place_err_q, place_err_d;
  logic [1:0]    shot_ack_q, shot_ack_d;
  logic          shot_hit_q, shot_hit_d;
  logic          shot_rep_q, shot_rep_d;
  logic [2:0]    cell_state_q, cell_state_d;

  logic          wr_en;
  logic          wr_board;
  logic [IW-1:0] wr_idx;
  logic [2:0]    wr_dat;

  logic          p_in, s_in, x_in;
  logic [IW-1:0] p_idx, s_idx, x_idx;
  logic [2:0]    p_cell, s_cell;
  logic          tgt_board;

  assign tgt_board = ~turn_q;

  assign p_in   = in_range(place_row, place_col);
  assign p_idx  = cell_idx(place_row, place_col);
  assign p_cell = cell_q[place_board][p_idx];

  assign s_in   = in_range(srow_q, scol_q);
  assign s_idx  = cell_idx(srow_q, scol_q);
  assign s_cell = cell_q[tgt_board][s_idx];

  assign x_in   = in_range(pix_row, pix_col);
  assign x_idx  = cell_idx(pix_row, pix_col);

  always_comb begin
    phase_d      = phase_q;
    turn_d       = turn_q;
    winner_d     = winner_q;
    ships_d      = ships_q;
    srow_d       = srow_q;
    scol_d       = scol_q;
    place_err_d  = 1'b0;
    shot_ack_d   = 2'b00;
    shot_hit_d   = 1'b0;
    shot_rep_d   = 1'b0;
    wr_en        = 1'b0;
    wr_board     = 1'b0;
    wr_idx       = '0;
    wr_dat       = C_WATER;
    cell_state_d = (pix_valid && x_in) ? cell_q[pix_board][x_idx] : C_NONE;

    case (phase_q)
      SETUP: begin
        if (place_valid) begin
          if (p_in && (p_cell == C_WATER) && (ships_q[place_board] < SW'(MAX_SHIPS))) begin
            wr_en                = 1'b1;
            wr_board             = place_board;
            wr_idx               = p_idx;
            wr_dat               = C_SHIP;
            ships_d[place_board] = ships_q[place_board] + SW'(1);
          end else begin
            place_err_d = 1'b1;
          end
        end
        // Start qualifies on the counters before any same-cycle placement lands.
        if (start && (ships_q[0] != '0) && (ships_q[1] != '0)) begin
          phase_d = WAIT_SHOT;
        end
      end

      WAIT_SHOT: begin
        if (shot_req[turn_q]) begin
          srow_d  = turn_q ? shot_row1 : shot_row0;
          scol_d  = turn_q ? shot_col1 : shot_col0;
          phase_d = RESOLVE;
        end
      end

      RESOLVE: begin
        shot_ack_d[turn_q] = 1'b1;
        phase_d            = WAIT_SHOT;
        if (s_in && (s_cell == C_WATER)) begin
          wr_en    = 1'b1;
          wr_board = tgt_board;
          wr_idx   = s_idx;
          wr_dat   = C_WATER_HIT;
          turn_d   = ~turn_q;
        end else if (s_in && (s_cell == C_SHIP)) begin
          wr_en              = 1'b1;
          wr_board           = tgt_board;
          wr_idx             = s_idx;
          wr_dat             = C_SHIP_HIT;
          shot_hit_d         = 1'b1;
          ships_d[tgt_board] = ships_q[tgt_board] - SW'(1);
          if (ships_q[tgt_board] == SW'(1)) begin
            phase_d  = DONE;
            winner_d = turn_q;
          end else begin
            turn_d = ~turn_q;
          end
        end else begin
          // Repeat or off-board shot: the same player gets another try.
          shot_rep_d = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= SETUP;
      turn_q       <= 1'b0;
      winner_q     <= 1'b0;
      srow_q       <= '0;
      scol_q       <= '0;
      place_err_q  <= 1'b0;
      shot_ack_q   <= 2'b00;
      shot_hit_q   <= 1'b0;
      shot_rep_q   <= 1'b0;
      cell_state_q <= C_NONE;
      for (int b = 0; b < 2; b++) begin
        ships_q[b] <= '0;
        for (int i = 0; i < NC; i++) begin
          cell_q[b][i] <= C_WATER;
        end
      end
    end else begin
      phase_q      <= phase_d;
      turn_q       <= turn_d;
      winner_q     <= winner_d;
      srow_q       <= srow_d;
      scol_q       <= scol_d;
      place_err_q  <= place_err_d;
      shot_ack_q   <= shot_ack_d;
      shot_hit_q   <= shot_hit_d;
      shot_rep_q   <= shot_rep_d;
      cell_state_q <= cell_state_d;
      ships_q      <= ships_d;
      if (wr_en) begin
        cell_q[wr_board][wr_idx] <= wr_dat;
      end
    end
  end

  assign place_err  = place_err_q;
  assign shot_ack   = shot_ack_q;
  assign shot_hit   = shot_hit_q;
  assign shot_rep   = shot_rep_q;
  assign cell_state = cell_state_q;
  assign phase      = phase_q;
  assign turn       = turn_q;
  assign game_over  = (phase_q == DONE);
  assign winner     = winner_q;

endmodule

// File: tb/tb_board_turn_ctrl.sv
// Directed vector table for board_turn_ctrl plus hand-written reset and player-1-win sequences.
module tb_board_turn_ctrl;

  logic       clk;
  logic       rst;
  logic       place_valid;
  logic       place_board;
  logic [2:0] place_row;
  logic [2:0] place_col;
  logic       place_err;
  logic       start;
  logic [1:0] shot_req;
  logic [2:0] shot_row0, shot_col0, shot_row1, shot_col1;
  logic [1:0] shot_ack;
  logic       shot_hit;
  logic       shot_rep;
  logic       pix_valid;
  logic       pix_board;
  logic [2:0] pix_row, pix_col;
  logic [2:0] cell_state;
  logic [1:0] phase;
  logic       turn;
  logic       game_over;
  logic       winner;

  board_turn_ctrl #(.ROWS(5), .COLS(5), .MAX_SHIPS(5), .RW(3), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .place_valid(place_valid), .place_board(place_board),
    .place_row(place_row), .place_col(place_col), .place_err(place_err),
    .start(start), .shot_req(shot_req),
    .shot_row0(shot_row0), .shot_col0(shot_col0),
    .shot_row1(shot_row1), .shot_col1(shot_col1),
    .shot_ack(shot_ack), .shot_hit(shot_hit), .shot_rep(shot_rep),
    .pix_valid(pix_valid), .pix_board(pix_board),
    .pix_row(pix_row), .pix_col(pix_col), .cell_state(cell_state),
    .phase(phase), .turn(turn), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one clock, then the outputs expected just after that edge.
  typedef struct {
    int rst, pv, pb, pr, pc, st, rq, r0, c0, r1, c1, xv, xb, xr, xc;
    int err, ack, hit, rep, cs, ph, tn, go, wn;
  } vec_t;

  localparam int NV = 41;
  vec_t tbl [NV];
  int   n_pass;
  int   n_total;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    place_valid = 0; place_board = 0; place_row = 0; place_col = 0;
    start = 0; shot_req = 0;
    shot_row0 = 0; shot_col0 = 0; shot_row1 = 0; shot_col1 = 0;
    pix_valid = 0; pix_board = 0; pix_row = 0; pix_col = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int act, exp;
    rst         = v.rst[0];
    place_valid = v.pv[0];
    place_board = v.pb[0];
    place_row   = v.pr[2:0];
    place_col   = v.pc[2:0];
    start       = v.st[0];
    shot_req    = v.rq[1:0];
    shot_row0   = v.r0[2:0];
    shot_col0   = v.c0[2:0];
    shot_row1   = v.r1[2:0];
    shot_col1   = v.c1[2:0];
    pix_valid   = v.xv[0];
    pix_board   = v.xb[0];
    pix_row     = v.xr[2:0];
    pix_col     = v.xc[2:0];
    step();
    act = int'({place_err, shot_ack, shot_hit, shot_rep, cell_state, phase, turn, game_over, winner});
    exp = (v.err << 12) | (v.ack << 10) | (v.hit << 9) | (v.rep << 8) | (v.cs << 5)
        | (v.ph << 3) | (v.tn << 2) | (v.go << 1) | v.wn;
    check($sformatf("vec%0d {err,ack,hit,rep,cs,ph,tn,go,win}", idx), act, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    idle_inputs();

    //          rst pv pb pr pc st rq r0 c0 r1 c1 xv xb xr xc  err ack hit rep cs ph tn go wn
    tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[2]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0};
    tbl[3]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0};
    tbl[4]  = '{1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[5]  = '{1,  1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3,  0,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[6]  = '{1,  1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3,  1,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[7]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[8]  = '{1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2, 3,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[9]  = '{1,  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[10] = '{1,  1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[11] = '{1,  1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[12] = '{1,  1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[13] = '{1,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 0, 0, 0, 0};
    tbl[14] = '{1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1,  1,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[15] = '{1,  1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1,  1,  0,  0,  0,  1, 0, 0, 0, 0};
    tbl[16] = '{1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 1, 0, 0, 0};
    tbl[17] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  3, 1, 0, 0, 0};
    tbl[18] = '{1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0,  0,  0,  0,  1, 2, 0, 0, 0};
    tbl[19] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0,  1,  0,  0,  1, 1, 1, 0, 0};
    tbl[20] = '{1,  0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0,  0,  0,  0,  0,  2, 1, 1, 0, 0};
    tbl[21] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 4, 4, 1, 1, 0, 0,  0,  0,  0,  0,  2, 2, 1, 0, 0};
    tbl[22] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 4,  0,  2,  0,  0,  1, 1, 0, 0, 0};
    tbl[23] = '{1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 4, 4,  0,  0,  0,  0,  2, 2, 0, 0, 0};
    tbl[24] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0,  1,  0,  1,  2, 1, 0, 0, 0};
    tbl[25] = '{1,  0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1,  0,  0,  0,  0,  1, 2, 0, 0, 0};
    tbl[26] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1,  0,  1,  0,  0,  1, 1, 1, 0, 0};
    tbl[27] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 4, 4, 1, 1, 1, 1,  0,  0,  0,  0,  2, 2, 1, 0, 0};
    tbl[28] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 4,  0,  2,  0,  1,  2, 1, 1, 0, 0};
    tbl[29] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 7, 7, 1, 0, 4, 4,  0,  0,  0,  0,  2, 2, 1, 0, 0};
    tbl[30] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 7, 7, 1, 0, 4, 4,  0,  2,  0,  1,  2, 1, 1, 0, 0};
    tbl[31] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 7, 7, 1, 0, 4, 4,  0,  0,  0,  0,  2, 2, 1, 0, 0};
    tbl[32] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 4,  0,  2,  0,  1,  2, 1, 1, 0, 0};
    tbl[33] = '{1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 1,  0,  0,  0,  0,  3, 2, 1, 0, 0};
    tbl[34] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  2,  1,  0,  3, 1, 0, 0, 0};
    tbl[35] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0,  0,  4, 1, 0, 0, 0};
    tbl[36] = '{1,  0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 1, 1, 2, 3,  0,  0,  0,  0,  3, 2, 0, 0, 0};
    tbl[37] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3,  0,  1,  1,  0,  3, 3, 0, 1, 0};
    tbl[38] = '{1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 3,  0,  0,  0,  0,  4, 3, 0, 1, 0};
    tbl[39] = '{1,  1, 0, 2, 2, 0, 3, 0, 0, 0, 0, 1, 0, 2, 2,  0,  0,  0,  0,  1, 3, 0, 1, 0};
    tbl[40] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 2,  0,  0,  0,  0,  1, 3, 0, 1, 0};

    for (int i = 0; i < NV; i++) apply_vec(tbl[i], i);

    // Reset sampled only at edges, and a reset landing on the RESOLVE edge suppresses the ack.
    idle_inputs();
    rst = 1'b0; step();
    rst = 1'b1;
    place_valid = 1; place_board = 0; place_row = 3; place_col = 3; step();
    place_board = 1; place_row = 0; place_col = 0; step();
    place_valid = 0; start = 1; step();
    start = 0;
    check("seq_start_phase", int'(phase), 1);
    shot_req = 2'b01; shot_row0 = 0; shot_col0 = 0; step();
    shot_req = 2'b00;
    check("seq_req_resolve", int'(phase), 2);
    #1 rst = 1'b0;
    #3;
    check("sync_rst_not_async", int'(phase), 2);
    step();
    check("rst_mid_resolve_ack", int'(shot_ack), 0);
    check("rst_mid_resolve_state", int'({phase, turn, game_over, winner, cell_state}), 0);
    rst = 1'b1;
    pix_valid = 1; pix_board = 1; pix_row = 0; pix_col = 0; step();
    check("rst_clears_target_cell", int'(cell_state), 1);

    // Player 1 wins on the single ship of board 0.
    place_valid = 1; place_board = 0; place_row = 3; place_col = 3; step();
    place_board = 1; place_row = 0; place_col = 0; step();
    place_valid = 0; start = 1; step();
    start = 0;
    shot_req = 2'b01; shot_row0 = 1; shot_col0 = 1; step();
    shot_req = 2'b00; step();
    check("p0_miss_ack_turn", int'({shot_ack, shot_hit, shot_rep, turn}), 5'b01001);
    shot_req = 2'b10; shot_row1 = 3; shot_col1 = 3; step();
    shot_req = 2'b00; step();
    check("p1_win_ack", int'({shot_ack, shot_hit, shot_rep}), 4'b1010);
    check("p1_win_state", int'({phase, turn, game_over, winner}), 5'b11111);
    shot_req = 2'b11; step(); step(); step();
    check("done_ignores_req", int'({shot_ack, phase}), 4'b0011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
